decode_hazard_ctrl: RTL and testbench
=====================================

DECODE_HAZARD_CTRL -- requirements
Module: decode_hazard_ctrl

Interface
REQ-001 Parameter STALL_CNT_W, default 16: width of the saturating stall-cycle counter.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 ctrl_in  input  lc3b_control_word  decoded control word of the instruction in ID.
REQ-005 id_valid  input  1  ID holds a real instruction.
REQ-006 id_sr1, id_sr2, id_dr  input  lc3b_reg each  source/destination register numbers of the ID instruction.
REQ-007 mem_stall  input  1  downstream memory not ready; freeze all state.
REQ-008 br_resolve  input  1  pending branch/jump/trap resolved this cycle, PC redirected.
REQ-009 ex_ctrl  output  lc3b_control_word  registered ID/EX control word.
REQ-010 ex_valid  output  1  ex_ctrl is a real instruction, not a bubble.
REQ-011 ex_dr  output  lc3b_reg  registered destination register.
REQ-012 id_hold  output  1  IF/ID must not advance this cycle.
REQ-013 stall_cnt  output  STALL_CNT_W  count of cycles with a bubble inserted.

Function
REQ-014 Hazard terms: sr1 hit = ctrl_in.sr1_needed && id_sr1 == tracked dest; sr2 hit likewise with sr2_needed; tracked dest counts only when its stage is valid and its load_regfile is 1.
REQ-015 Tracked stages: EX (ex_ctrl/ex_dr/ex_valid) and MEM (one internal shadow register of dr, load_regfile, mem_read and valid, loaded from EX each advancing cycle).
REQ-016 Load-use: EX instruction with mem_read=1 and a hit -> raw_stall=1.
REQ-017 FSM states IDLE, BR_WAIT; IDLE -> BR_WAIT when an instruction with branch_stall=1 issues to EX; BR_WAIT -> IDLE when br_resolve=1.
REQ-018 id_hold = mem_stall || raw_stall || state==BR_WAIT || (state==IDLE && issuing a branch_stall instruction).
REQ-019 Issue: when mem_stall=0, id_valid=1, raw_stall=0, state==IDLE -> ex_ctrl<=ctrl_in, ex_dr<=id_dr, ex_valid<=1 next edge (latency one cycle).
REQ-020 Bubble: when mem_stall=0 and issue blocked -> ex_ctrl<=0, ex_valid<=0, stall_cnt+1 only if id_valid=1.
REQ-021 mem_stall=1 -> EX, MEM shadow, FSM and stall_cnt hold, br_resolve ignored.
REQ-022 br_resolve in IDLE has no effect; br_resolve and a new branch issue in the same cycle from BR_WAIT: no issue that cycle (BR_WAIT blocks issue).
REQ-023 stall_cnt saturates at all-ones, never wraps.
REQ-024 id_valid=0 with no hazard -> bubble issued, stall_cnt unchanged.

Reset
REQ-025 reset=1 -> immediately ex_ctrl=0, ex_valid=0, ex_dr=0, MEM shadow cleared, state=IDLE, stall_cnt=0; id_hold reflects cleared state (0 unless mem_stall).
REQ-026 reset mid-BR_WAIT or mid-bubble abandons the operation; first post-reset instruction issues normally.

Configuration
REQ-027 Macro DECODE_FORWARDING_EN: defined -> only REQ-016 load-use hits stall; undefined -> any sr1/sr2 hit against EX or MEM tracked dest stalls until the writer leaves MEM.

Structure
REQ-028 lc3b_types holds lc3b_control_word, lc3b_reg and new enum lc3b_hz_state {IDLE, BR_WAIT}.
REQ-029 One sub-module raw_hazard_check: combinational sr1/sr2 vs one stage dest compare, instantiated per tracked stage.

Verification
REQ-030 LDR R1 then ADD R2,R1,R3 back-to-back -> one bubble (ex_valid=0 one cycle), id_hold=1 one cycle, stall_cnt=1.
REQ-031 BR issued -> id_hold=1 until br_resolve pulsed 3 cycles later; 3 bubbles, then next instruction issues the cycle after.
REQ-032 Without DECODE_FORWARDING_EN: ADD R1 then AND R4,R1,#1 -> two bubbles; with it -> zero bubbles.
REQ-033 mem_stall=1 for 4 cycles during BR_WAIT with br_resolve pulsed inside -> all outputs frozen, remains BR_WAIT.
REQ-034 stall_cnt preloaded near max by forcing sustained BR_WAIT with STALL_CNT_W=4 -> saturates at 15.
REQ-035 reset asserted asynchronously mid-cycle during BR_WAIT -> ex_valid=0, stall_cnt=0, state IDLE before next edge.

Source files
------------

// File: rtl/lc3b_types.sv
// -----------------------------------------------------------------------------
// lc3b_types
// Shared types for the LC-3b decode stage:
//   lc3b_reg           - architectural register number (R0..R7)
//   lc3b_control_word  - decoded control word carried down the pipe
//   lc3b_hz_state      - hazard controller branch-wait state
//   lc3b_stage_shadow  - minimal copy of a downstream stage used for hazard
//                        tracking (destination, write enable, load, valid)
// -----------------------------------------------------------------------------
package lc3b_types;

  typedef logic [2:0] lc3b_reg;

  typedef struct packed {
    logic [3:0] opcode;
    logic       sr1_needed;
    logic       sr2_needed;
    logic       load_regfile;
    logic       mem_read;
    logic       mem_write;
    logic       branch_stall;
  } lc3b_control_word;

  typedef enum logic {
    IDLE,
    BR_WAIT
  } lc3b_hz_state;

  typedef struct packed {
    lc3b_reg dr;
    logic    load_regfile;
    logic    mem_read;
    logic    valid;
  } lc3b_stage_shadow;

endpackage

// File: rtl/decode_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// decode_hazard_ctrl_if
// Bundle of the ID-side inputs and ID/EX outputs of decode_hazard_ctrl.
//   master : drives ctrl_in, id_valid, id_sr1, id_sr2, id_dr, mem_stall,
//            br_resolve; observes ex_ctrl, ex_valid, ex_dr, id_hold, stall_cnt
//   slave  : the hazard controller (opposite directions)
// Parameter STALL_CNT_W must match the controller it connects to.
// -----------------------------------------------------------------------------
interface decode_hazard_ctrl_if
  import lc3b_types::*;
#(
  parameter int STALL_CNT_W = 16
) ();

  lc3b_control_word       ctrl_in;
  logic                   id_valid;
  lc3b_reg                id_sr1;
  lc3b_reg                id_sr2;
  lc3b_reg                id_dr;
  logic                   mem_stall;
  logic                   br_resolve;
  lc3b_control_word       ex_ctrl;
  logic                   ex_valid;
  lc3b_reg                ex_dr;
  logic                   id_hold;
  logic [STALL_CNT_W-1:0] stall_cnt;

  modport master (
    output ctrl_in, id_valid, id_sr1, id_sr2, id_dr, mem_stall, br_resolve,
    input  ex_ctrl, ex_valid, ex_dr, id_hold, stall_cnt
  );

  modport slave (
    input  ctrl_in, id_valid, id_sr1, id_sr2, id_dr, mem_stall, br_resolve,
    output ex_ctrl, ex_valid, ex_dr, id_hold, stall_cnt
  );

endinterface

// File: rtl/raw_hazard_check.sv
// -----------------------------------------------------------------------------
// raw_hazard_check
// Combinational read-after-write compare of the ID instruction's sources
// against the destination of one downstream stage.
//   i_sr1_needed/i_sr2_needed : ID instruction actually reads sr1/sr2
//   i_sr1/i_sr2               : ID source register numbers
//   i_dest_valid              : stage holds a real instruction that writes
//   i_dest                    : stage destination register
//   o_hit                     : any needed source matches the destination
// -----------------------------------------------------------------------------
module raw_hazard_check
  import lc3b_types::*;
(
  input  logic    i_sr1_needed,
  input  logic    i_sr2_needed,
  input  lc3b_reg i_sr1,
  input  lc3b_reg i_sr2,
  input  logic    i_dest_valid,
  input  lc3b_reg i_dest,
  output logic    o_hit
);

  logic w_sr1_hit;
  logic w_sr2_hit;

  assign w_sr1_hit = i_sr1_needed && (i_sr1 == i_dest);
  assign w_sr2_hit = i_sr2_needed && (i_sr2 == i_dest);
  assign o_hit     = i_dest_valid && (w_sr1_hit || w_sr2_hit);

endmodule

// File: rtl/decode_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// decode_hazard_ctrl
// ID-stage hazard controller and ID/EX pipeline register for the LC-3b.
// Inserts bubbles for register RAW hazards and while a branch/jump/trap is
// unresolved, freezes on downstream memory stalls, and counts bubble cycles.
//
// Ports:
//   clk    - clock, rising edge
//   reset  - asynchronous, active-high reset
//   bus    - decode_hazard_ctrl_if.slave:
//              in : ctrl_in, id_valid, id_sr1, id_sr2, id_dr, mem_stall,
//                   br_resolve
//              out: ex_ctrl, ex_valid, ex_dr, id_hold, stall_cnt
// Parameter:
//   STALL_CNT_W - width of the saturating bubble counter
// Build option:
//   DECODE_FORWARDING_EN - when defined, the datapath forwards results, so
//   only a load followed immediately by a consumer stalls. When undefined,
//   any consumer waits until its producer has left MEM.
// -----------------------------------------------------------------------------
module decode_hazard_ctrl
  import lc3b_types::*;
#(
  parameter int STALL_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  decode_hazard_ctrl_if.slave  bus
);

  localparam logic [STALL_CNT_W-1:0] STALL_MAX = '1;
  localparam logic [STALL_CNT_W-1:0] STALL_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

  lc3b_hz_state           r_state;
  lc3b_hz_state           w_state_next;
  lc3b_control_word       r_ex_ctrl;
  logic                   r_ex_valid;
  lc3b_reg                r_ex_dr;
  lc3b_stage_shadow       r_mem;
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  logic w_ex_dest_valid;
  logic w_mem_dest_valid;
  logic w_ex_hit;
  logic w_mem_hit;
  logic w_raw_stall;
  logic w_issue_ok;
  logic w_issue;
  logic w_advance;
  logic w_unused;

  // A stage only matters as a producer when it is real and writes the file.
  assign w_ex_dest_valid  = r_ex_valid && r_ex_ctrl.load_regfile;
  assign w_mem_dest_valid = r_mem.valid && r_mem.load_regfile;

  raw_hazard_check u_ex_check (
    .i_sr1_needed (bus.ctrl_in.sr1_needed),
    .i_sr2_needed (bus.ctrl_in.sr2_needed),
    .i_sr1        (bus.id_sr1),
    .i_sr2        (bus.id_sr2),
    .i_dest_valid (w_ex_dest_valid),
    .i_dest       (r_ex_dr),
    .o_hit        (w_ex_hit)
  );

  raw_hazard_check u_mem_check (
    .i_sr1_needed (bus.ctrl_in.sr1_needed),
    .i_sr2_needed (bus.ctrl_in.sr2_needed),
    .i_sr1        (bus.id_sr1),
    .i_sr2        (bus.id_sr2),
    .i_dest_valid (w_mem_dest_valid),
    .i_dest       (r_mem.dr),
    .o_hit        (w_mem_hit)
  );

`ifdef DECODE_FORWARDING_EN
  // Forwarding covers everything except load data, which only exists after MEM.
  assign w_raw_stall = bus.id_valid && w_ex_hit && r_ex_ctrl.mem_read;
  assign w_unused    = r_mem.mem_read ^ w_mem_hit;
`else
  assign w_raw_stall = bus.id_valid && (w_ex_hit || w_mem_hit);
  assign w_unused    = r_mem.mem_read;
`endif

  assign w_advance  = !bus.mem_stall;
  assign w_issue_ok = bus.id_valid && !w_raw_stall && (r_state == IDLE);
  assign w_issue    = w_issue_ok && w_advance;

  // A branch holds IF/ID in the very cycle it issues, so the wrong-path
  // instruction behind it never reaches EX.
  assign bus.id_hold = bus.mem_stall || w_raw_stall || (r_state == BR_WAIT) ||
                       (w_issue_ok && bus.ctrl_in.branch_stall);

  assign bus.ex_ctrl   = r_ex_ctrl;
  assign bus.ex_valid  = r_ex_valid;
  assign bus.ex_dr     = r_ex_dr;
  assign bus.stall_cnt = r_stall_cnt;

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_issue && bus.ctrl_in.branch_stall) w_state_next = BR_WAIT;
      BR_WAIT: if (w_advance && bus.br_resolve)         w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ex_ctrl   <= '0;
      r_ex_valid  <= 1'b0;
      r_ex_dr     <= '0;
      r_mem       <= '0;
      r_stall_cnt <= '0;
    end else if (w_advance) begin
      r_mem <= '{dr:           r_ex_dr,
                 load_regfile: r_ex_ctrl.load_regfile,
                 mem_read:     r_ex_ctrl.mem_read,
                 valid:        r_ex_valid};
      if (w_issue) begin
        r_ex_ctrl  <= bus.ctrl_in;
        r_ex_dr    <= bus.id_dr;
        r_ex_valid <= 1'b1;
      end else begin
        // Bubble: an all-zero word so downstream sees no side effects.
        r_ex_ctrl  <= '0;
        r_ex_dr    <= '0;
        r_ex_valid <= 1'b0;
        // Only a real instruction being held back counts as a stall cycle.
        if (bus.id_valid && (r_stall_cnt != STALL_MAX)) begin
          r_stall_cnt <= r_stall_cnt + STALL_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
module tb_decode_hazard_ctrl;
  import lc3b_types::*;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  decode_hazard_ctrl_if #(.STALL_CNT_W(16)) bus ();
  decode_hazard_ctrl_if #(.STALL_CNT_W(4))  bus4 ();

  decode_hazard_ctrl #(.STALL_CNT_W(16)) dut  (.clk(clk), .reset(reset), .bus(bus));
  decode_hazard_ctrl #(.STALL_CNT_W(4))  dut4 (.clk(clk), .reset(reset), .bus(bus4));

  typedef struct {
    logic             v;
    lc3b_control_word c;
    lc3b_reg          s1, s2, d;
    logic             ms, br;
    logic             hold;
    logic             ev;
    lc3b_control_word ec;
    lc3b_reg          ed;
  } step_t;

  typedef struct {
    logic             v;
    lc3b_control_word c;
    lc3b_reg          d;
  } exp_t;

  exp_t exp_q[$];

  lc3b_control_word cw_ldr, cw_add, cw_andi, cw_str, cw_br, cw_jmp;

`ifdef DECODE_FORWARDING_EN
  localparam int LOAD_USE_BUBBLES = 1;
  localparam int ALU_USE_BUBBLES  = 0;
`else
  localparam int LOAD_USE_BUBBLES = 2;
  localparam int ALU_USE_BUBBLES  = 2;
`endif

  function automatic lc3b_control_word cw(input logic [3:0] op, input logic n1, n2, ld,
                                          mrd, mwr, br);
    lc3b_control_word w;
    w.opcode = op; w.sr1_needed = n1; w.sr2_needed = n2; w.load_regfile = ld;
    w.mem_read = mrd; w.mem_write = mwr; w.branch_stall = br;
    return w;
  endfunction

  function automatic step_t st(input logic v, input lc3b_control_word c,
                               input lc3b_reg s1, s2, d, input logic ms, br, hold, ev,
                               input lc3b_control_word ec, input lc3b_reg ed);
    step_t s;
    s.v = v; s.c = c; s.s1 = s1; s.s2 = s2; s.d = d; s.ms = ms; s.br = br;
    s.hold = hold; s.ev = ev; s.ec = ec; s.ed = ed;
    return s;
  endfunction

  function automatic step_t idle_step(input logic br, hold);
    return st(1'b0, '0, 3'd0, 3'd0, 3'd0, 1'b0, br, hold, 1'b0, '0, 3'd0);
  endfunction

  // Drive one cycle of ID inputs and record what EX must hold after the edge.
  task automatic drive(input step_t s);
    bus.id_valid   = s.v;
    bus.ctrl_in    = s.c;
    bus.id_sr1     = s.s1;
    bus.id_sr2     = s.s2;
    bus.id_dr      = s.d;
    bus.mem_stall  = s.ms;
    bus.br_resolve = s.br;
    exp_q.push_back('{s.ev, s.ec, s.ed});
  endtask

  task automatic idle4();
    bus4.id_valid = 1'b0; bus4.ctrl_in = '0; bus4.id_sr1 = '0; bus4.id_sr2 = '0;
    bus4.id_dr = '0; bus4.mem_stall = 1'b0; bus4.br_resolve = 1'b0;
  endtask

  task automatic do_reset();
    drive(idle_step(1'b0, 1'b0));
    exp_q.delete();
    idle4();
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    drive(idle_step(1'b0, 1'b0));
    exp_q.delete();
    idle4();
    reset = 1'b1;
    #2;
    total++; if (bus.ex_valid !== 1'b0) begin bad++; $display("FAIL reset ex_valid: got %b want 0", bus.ex_valid); end
    total++; if (bus.ex_ctrl !== '0) begin bad++; $display("FAIL reset ex_ctrl: got %h want 0", bus.ex_ctrl); end
    total++; if (bus.ex_dr !== 3'd0) begin bad++; $display("FAIL reset ex_dr: got %0d want 0", bus.ex_dr); end
    total++; if (bus.stall_cnt !== 16'd0) begin bad++; $display("FAIL reset stall_cnt: got %0d want 0", bus.stall_cnt); end
    total++; if (bus.id_hold !== 1'b0) begin bad++; $display("FAIL reset id_hold: got %b want 0", bus.id_hold); end
    bus.mem_stall = 1'b1;
    #1;
    total++; if (bus.id_hold !== 1'b1) begin bad++; $display("FAIL reset id_hold_mem_stall: got %b want 1", bus.id_hold); end
    bus.mem_stall = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_load_use();
    step_t s[$];
    exp_t  e;
    do_reset();
    s.push_back(st(1, cw_ldr, 3'd2, 3'd0, 3'd1, 0, 0, 0, 1, cw_ldr, 3'd1));
    for (int k = 0; k < LOAD_USE_BUBBLES; k++)
      s.push_back(st(1, cw_add, 3'd1, 3'd3, 3'd2, 0, 0, 1, 0, '0, 3'd0));
    s.push_back(st(1, cw_add, 3'd1, 3'd3, 3'd2, 0, 0, 0, 1, cw_add, 3'd2));
    s.push_back(idle_step(1'b0, 1'b0));
    foreach (s[i]) begin
      drive(s[i]);
      #1;
      total++; if (bus.id_hold !== s[i].hold) begin bad++; $display("FAIL load_use hold step %0d: got %b want %b", i, bus.id_hold, s[i].hold); end
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total++;
      if ({bus.ex_valid, bus.ex_ctrl, bus.ex_dr} !== {e.v, e.c, e.d}) begin
        bad++; $display("FAIL load_use ex step %0d: got v=%b c=%h d=%0d want v=%b c=%h d=%0d",
                        i, bus.ex_valid, bus.ex_ctrl, bus.ex_dr, e.v, e.c, e.d);
      end
    end
    total++; if (bus.stall_cnt !== 16'(LOAD_USE_BUBBLES)) begin bad++; $display("FAIL load_use stall_cnt: got %0d want %0d", bus.stall_cnt, LOAD_USE_BUBBLES); end
  endtask

  task automatic test_forwarding();
    step_t s[$];
    exp_t  e;
    do_reset();
    s.push_back(st(1, cw_add, 3'd2, 3'd3, 3'd1, 0, 0, 0, 1, cw_add, 3'd1));
    for (int k = 0; k < ALU_USE_BUBBLES; k++)
      s.push_back(st(1, cw_andi, 3'd1, 3'd0, 3'd4, 0, 0, 1, 0, '0, 3'd0));
    s.push_back(st(1, cw_andi, 3'd1, 3'd0, 3'd4, 0, 0, 0, 1, cw_andi, 3'd4));
    // sr2 field equals the EX destination but is not read: no hazard
    s.push_back(st(1, cw_andi, 3'd2, 3'd4, 3'd5, 0, 0, 0, 1, cw_andi, 3'd5));
    s.push_back(st(1, cw_str,  3'd6, 3'd7, 3'd3, 0, 0, 0, 1, cw_str, 3'd3));
    // the store does not write R3, so reading R3 is free
    s.push_back(st(1, cw_add,  3'd3, 3'd3, 3'd6, 0, 0, 0, 1, cw_add, 3'd6));
    s.push_back(idle_step(1'b0, 1'b0));
    foreach (s[i]) begin
      drive(s[i]);
      #1;
      total++; if (bus.id_hold !== s[i].hold) begin bad++; $display("FAIL fwd hold step %0d: got %b want %b", i, bus.id_hold, s[i].hold); end
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total++;
      if ({bus.ex_valid, bus.ex_ctrl, bus.ex_dr} !== {e.v, e.c, e.d}) begin
        bad++; $display("FAIL fwd ex step %0d: got v=%b c=%h d=%0d want v=%b c=%h d=%0d",
                        i, bus.ex_valid, bus.ex_ctrl, bus.ex_dr, e.v, e.c, e.d);
      end
    end
    total++; if (bus.stall_cnt !== 16'(ALU_USE_BUBBLES)) begin bad++; $display("FAIL fwd stall_cnt: got %0d want %0d", bus.stall_cnt, ALU_USE_BUBBLES); end
  endtask

  task automatic test_branch();
    step_t s[$];
    exp_t  e;
    do_reset();
    s.push_back(idle_step(1'b1, 1'b0));
    s.push_back(st(1, cw_br,  3'd0, 3'd0, 3'd0, 0, 0, 1, 1, cw_br, 3'd0));
    s.push_back(st(1, cw_add, 3'd0, 3'd7, 3'd5, 0, 0, 1, 0, '0, 3'd0));
    s.push_back(st(1, cw_add, 3'd0, 3'd7, 3'd5, 0, 0, 1, 0, '0, 3'd0));
    s.push_back(st(1, cw_add, 3'd0, 3'd7, 3'd5, 0, 1, 1, 0, '0, 3'd0));
    s.push_back(st(1, cw_add, 3'd0, 3'd7, 3'd5, 0, 0, 0, 1, cw_add, 3'd5));
    s.push_back(idle_step(1'b0, 1'b0));
    foreach (s[i]) begin
      drive(s[i]);
      #1;
      total++; if (bus.id_hold !== s[i].hold) begin bad++; $display("FAIL branch hold step %0d: got %b want %b", i, bus.id_hold, s[i].hold); end
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total++;
      if ({bus.ex_valid, bus.ex_ctrl, bus.ex_dr} !== {e.v, e.c, e.d}) begin
        bad++; $display("FAIL branch ex step %0d: got v=%b c=%h d=%0d want v=%b c=%h d=%0d",
                        i, bus.ex_valid, bus.ex_ctrl, bus.ex_dr, e.v, e.c, e.d);
      end
    end
    total++; if (bus.stall_cnt !== 16'd3) begin bad++; $display("FAIL branch stall_cnt: got %0d want 3", bus.stall_cnt); end
  endtask

  task automatic test_br_same_cycle();
    step_t s[$];
    exp_t  e;
    do_reset();
    s.push_back(st(1, cw_br,  3'd0, 3'd0, 3'd0, 0, 0, 1, 1, cw_br, 3'd0));
    s.push_back(st(1, cw_jmp, 3'd2, 3'd0, 3'd0, 0, 1, 1, 0, '0, 3'd0));
    s.push_back(st(1, cw_jmp, 3'd2, 3'd0, 3'd0, 0, 0, 1, 1, cw_jmp, 3'd0));
    s.push_back(idle_step(1'b1, 1'b1));
    s.push_back(idle_step(1'b0, 1'b0));
    foreach (s[i]) begin
      drive(s[i]);
      #1;
      total++; if (bus.id_hold !== s[i].hold) begin bad++; $display("FAIL br_same hold step %0d: got %b want %b", i, bus.id_hold, s[i].hold); end
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total++;
      if ({bus.ex_valid, bus.ex_ctrl, bus.ex_dr} !== {e.v, e.c, e.d}) begin
        bad++; $display("FAIL br_same ex step %0d: got v=%b c=%h d=%0d want v=%b c=%h d=%0d",
                        i, bus.ex_valid, bus.ex_ctrl, bus.ex_dr, e.v, e.c, e.d);
      end
    end
    total++; if (bus.stall_cnt !== 16'd1) begin bad++; $display("FAIL br_same stall_cnt: got %0d want 1", bus.stall_cnt); end
  endtask

  task automatic test_mem_stall();
    step_t s[$];
    exp_t  e;
    do_reset();
    s.push_back(st(1, cw_br,  3'd0, 3'd0, 3'd0, 0, 0, 1, 1, cw_br, 3'd0));
    s.push_back(st(1, cw_add, 3'd0, 3'd7, 3'd5, 1, 0, 1, 1, cw_br, 3'd0));
    s.push_back(st(1, cw_add, 3'd0, 3'd7, 3'd5, 1, 1, 1, 1, cw_br, 3'd0));
    s.push_back(st(1, cw_add, 3'd0, 3'd7, 3'd5, 1, 0, 1, 1, cw_br, 3'd0));
    s.push_back(st(1, cw_add, 3'd0, 3'd7, 3'd5, 1, 0, 1, 1, cw_br, 3'd0));
    s.push_back(st(1, cw_add, 3'd0, 3'd7, 3'd5, 0, 0, 1, 0, '0, 3'd0));
    s.push_back(st(1, cw_add, 3'd0, 3'd7, 3'd5, 0, 1, 1, 0, '0, 3'd0));
    s.push_back(st(1, cw_add, 3'd0, 3'd7, 3'd5, 0, 0, 0, 1, cw_add, 3'd5));
    s.push_back(idle_step(1'b0, 1'b0));
    foreach (s[i]) begin
      drive(s[i]);
      #1;
      total++; if (bus.id_hold !== s[i].hold) begin bad++; $display("FAIL mem_stall hold step %0d: got %b want %b", i, bus.id_hold, s[i].hold); end
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total++;
      if ({bus.ex_valid, bus.ex_ctrl, bus.ex_dr} !== {e.v, e.c, e.d}) begin
        bad++; $display("FAIL mem_stall ex step %0d: got v=%b c=%h d=%0d want v=%b c=%h d=%0d",
                        i, bus.ex_valid, bus.ex_ctrl, bus.ex_dr, e.v, e.c, e.d);
      end
      if (i == 4) begin
        total++; if (bus.stall_cnt !== 16'd0) begin bad++; $display("FAIL mem_stall frozen stall_cnt: got %0d want 0", bus.stall_cnt); end
      end
    end
    total++; if (bus.stall_cnt !== 16'd2) begin bad++; $display("FAIL mem_stall stall_cnt: got %0d want 2", bus.stall_cnt); end
  endtask

  task automatic test_saturation();
    do_reset();
    total++; if (bus4.stall_cnt !== 4'd0) begin bad++; $display("FAIL sat start: got %0d want 0", bus4.stall_cnt); end
    bus4.id_valid = 1'b1; bus4.ctrl_in = cw_br;
    @(posedge clk); #1;
    bus4.ctrl_in = cw_add; bus4.id_sr1 = 3'd0; bus4.id_sr2 = 3'd7; bus4.id_dr = 3'd5;
    repeat (14) @(posedge clk);
    #1;
    total++; if (bus4.stall_cnt !== 4'd14) begin bad++; $display("FAIL sat count14: got %0d want 14", bus4.stall_cnt); end
    @(posedge clk); #1;
    total++; if (bus4.stall_cnt !== 4'd15) begin bad++; $display("FAIL sat count15: got %0d want 15", bus4.stall_cnt); end
    repeat (5) @(posedge clk);
    #1;
    total++; if (bus4.stall_cnt !== 4'd15) begin bad++; $display("FAIL sat hold15: got %0d want 15", bus4.stall_cnt); end
    total++; if (bus4.id_hold !== 1'b1) begin bad++; $display("FAIL sat id_hold: got %b want 1", bus4.id_hold); end
    bus4.br_resolve = 1'b1;
    @(posedge clk); #1;
    bus4.br_resolve = 1'b0;
    @(posedge clk); #1;
    total++; if (bus4.ex_valid !== 1'b1 || bus4.ex_dr !== 3'd5) begin bad++; $display("FAIL sat issue_after: got v=%b d=%0d want v=1 d=5", bus4.ex_valid, bus4.ex_dr); end
    idle4();
  endtask

  task automatic test_async_reset();
    step_t a;
    do_reset();
    drive(st(1, cw_br, 3'd0, 3'd0, 3'd0, 0, 0, 1, 1, cw_br, 3'd0));
    @(posedge clk); #1;
    a = st(1, cw_add, 3'd0, 3'd7, 3'd5, 0, 0, 1, 0, '0, 3'd0);
    drive(a);
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    total++; if (bus.stall_cnt !== 16'd2) begin bad++; $display("FAIL async pre stall_cnt: got %0d want 2", bus.stall_cnt); end
    #3 reset = 1'b1;
    #1;
    total++; if (bus.ex_valid !== 1'b0) begin bad++; $display("FAIL async ex_valid: got %b want 0", bus.ex_valid); end
    total++; if (bus.ex_ctrl !== '0) begin bad++; $display("FAIL async ex_ctrl: got %h want 0", bus.ex_ctrl); end
    total++; if (bus.stall_cnt !== 16'd0) begin bad++; $display("FAIL async stall_cnt: got %0d want 0", bus.stall_cnt); end
    total++; if (bus.id_hold !== 1'b0) begin bad++; $display("FAIL async id_hold: got %b want 0", bus.id_hold); end
    #2 reset = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({bus.ex_valid, bus.ex_ctrl, bus.ex_dr} !== {1'b1, cw_add, 3'd5}) begin
      bad++; $display("FAIL async first_issue: got v=%b c=%h d=%0d want v=1 c=%h d=5",
                      bus.ex_valid, bus.ex_ctrl, bus.ex_dr, cw_add);
    end
    drive(idle_step(1'b0, 1'b0));
    exp_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cw_ldr  = cw(4'h6, 1, 0, 1, 1, 0, 0);
    cw_add  = cw(4'h1, 1, 1, 1, 0, 0, 0);
    cw_andi = cw(4'h5, 1, 0, 1, 0, 0, 0);
    cw_str  = cw(4'h7, 1, 1, 0, 0, 1, 0);
    cw_br   = cw(4'h0, 0, 0, 0, 0, 0, 1);
    cw_jmp  = cw(4'hC, 1, 0, 0, 0, 0, 1);
    reset = 1'b0;
    test_reset();
    test_load_use();
    test_forwarding();
    test_branch();
    test_br_same_cycle();
    test_mem_stall();
    test_saturation();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
